dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder end of the core data-memory interface: accepts load/store requests from the CPU core, checks alignment, and drives `mem_stall` while the access is in progress.
- Converts each request into a single Wishbone-style classic bus cycle toward the data cache / memory backend.
- Performs byte-lane steering on writes and lane extraction plus sign/zero extension on reads.
- Honours `dc_lock` so that an access is never issued twice while the pipeline is frozen.

Parameters:
- TIMEOUT, 255: bus cycles allowed without `wb_ack` before the access is aborted with `bus_err`. 0 disables the timeout.

Ports:
- clk  in  1  main clock
- rst  in  1  reset, asynchronous, active-high
- mem_ren  in  1  core read request
- mem_wen  in  1  core write request
- mem_type  in  2  access size: 00 byte, 01 half, 11 word, 10 treated as word
- mem_ext  in  1  1 = sign-extend read data, 0 = zero-extend
- mem_addr  in  32  byte address
- mem_dout  in  32  store data from core (right-aligned)
- mem_din  out  32  load data to core (right-aligned, extended)
- mem_stall  out  1  core must hold its request and freeze
- mem_unalign  out  1  misaligned request flag
- dc_lock  in  1  1 = core has not advanced; the current request is the same one
- wb_cyc  out  1  bus cycle
- wb_stb  out  1  bus strobe
- wb_we  out  1  bus write
- wb_addr  out  30  word address, equal to mem_addr[31:2]
- wb_sel  out  4  byte enables, bit i = byte lane i (little-endian)
- wb_dout  out  32  bus write data
- wb_din  in  32  bus read data
- wb_ack  in  1  bus acknowledge
- bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, any state): state=IDLE; wb_cyc=wb_stb=wb_we=0; wb_addr=0; wb_sel=0; wb_dout=0; mem_din=0; bus_err=0; timeout counter=0.
- Request: `req = mem_ren | mem_wen`. If both are high, the request is treated as a write.
- Alignment (combinational):
  - `mem_unalign = req & ((type==01 & addr[0]) | (type[1] & addr[1:0]!=0))`.
  - A misaligned request never starts a bus cycle and never raises mem_stall.
- States:
  - IDLE: `mem_stall = req & ~mem_unalign`. On such a request, register wb_addr, wb_we, wb_sel, wb_dout and go to BUS.
  - BUS: wb_cyc=wb_stb=1; mem_stall=1.
    - On wb_ack: capture the extracted read data into mem_din (reads only; writes leave mem_din unchanged), drop cyc/stb at that edge, go to DONE.
    - On counter==TIMEOUT-1 without ack: mem_din=0, bus_err=1 for one cycle, go to DONE.
  - DONE: mem_stall=0; mem_din is held stable.
    - dc_lock=1: stay in DONE, with no re-issue even though the core is still presenting the same request.
    - dc_lock=0: go to IDLE. A new request is evaluated the following cycle.
- Write steering:
  - byte: wb_dout={4{d[7:0]}}, wb_sel=0001<<addr[1:0].
  - half: wb_dout={2{d[15:0]}}, wb_sel = addr[1] ? 1100 : 0011.
  - word: wb_dout=d, wb_sel=1111.
- Read extraction: take byte lane addr[1:0] or half lane addr[1] from wb_din, then sign- or zero-extend to 32 bits per mem_ext. Reads also drive wb_sel per size.
- Latency with a zero-wait slave (ack in the first BUS cycle): request in cycle 0 (stall=1), BUS in cycle 1 (stall=1), DONE in cycle 2 (stall=0, data valid). Each slave wait state adds one cycle.
- Core inputs must remain stable while mem_stall=1; changes there are undefined.
- The timeout counter clears on entry to BUS and counts each BUS cycle without ack.
- wb_ack outside BUS is ignored.

Test Plan:
- Word read, addr=0x100, wb_din=0x89ABCDEF, ack in first BUS cycle -> stall high for 2 cycles; mem_din=0x89ABCDEF in cycle 2; wb_sel=1111; wb_addr=0x40.
- Byte read with sign extension, addr=0x103, ext=1, wb_din=0x80xxxxxx -> mem_din=0xFFFFFF80. Same with ext=0 -> 0x00000080.
- Half write, addr=0x202, dout=0x0000BEEF -> wb_we=1, wb_sel=1100, wb_dout=0xBEEFBEEF. Holding dc_lock=1 for 5 cycles after completion -> exactly one wb_stb cycle.
- Word read at addr=0x101 -> mem_unalign=1, mem_stall=0, wb_cyc never asserted. Half read at addr=0x101 -> mem_unalign=1.
- TIMEOUT=4, slave never acks -> 4 BUS cycles, then bus_err pulses for one cycle, mem_din=0, stall drops.
- Assert rst during BUS with 2 wait states -> wb_cyc/wb_stb drop asynchronously; after release, state=IDLE and a fresh request completes normally.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: turns core load/store requests into single classic
// Wishbone cycles, with byte-lane steering, read extension and a bus timeout.
module dmem_responder #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [1:0]  mem_type,
    input  logic        mem_ext,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_unalign,
    input  logic        dc_lock,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [29:0] wb_addr,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_dout,
    input  logic [31:0] wb_din,
    input  logic        wb_ack,
    output logic        bus_err
);

    // state | meaning
    // IDLE  | waiting for an aligned request; stalls the core combinationally
    // BUS   | classic bus cycle in flight, waiting for wb_ack or timeout
    // DONE  | access finished, data held; waits for dc_lock to clear
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int  CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit  TO_EN = (TIMEOUT != 0);

    state_t        state;
    logic [CW-1:0] to_cnt;
    logic [1:0]    rd_type;
    logic [1:0]    rd_lane;
    logic          rd_ext;

    logic          req;
    logic          to_hit;
    logic [3:0]    sel_next;
    logic [31:0]   dout_next;
    logic [31:0]   rd_data;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;

    assign req    = mem_ren | mem_wen;
    assign to_hit = TO_EN && (to_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        mem_unalign = req & (((mem_type == 2'b01) & mem_addr[0]) |
                             (mem_type[1] & (mem_addr[1:0] != 2'b00)));
    end

    always_comb begin
        mem_stall = 1'b0;
        case (state)
            S_IDLE:  mem_stall = req & ~mem_unalign;
            S_BUS:   mem_stall = 1'b1;
            default: mem_stall = 1'b0;
        endcase
    end

    // Lane steering: sub-word stores are replicated across the word so the
    // byte enables alone select the target lane.
    always_comb begin
        sel_next  = 4'b1111;
        dout_next = mem_dout;
        case (mem_type)
            2'b00: begin
                sel_next  = 4'b0001 << mem_addr[1:0];
                dout_next = {4{mem_dout[7:0]}};
            end
            2'b01: begin
                sel_next  = mem_addr[1] ? 4'b1100 : 4'b0011;
                dout_next = {2{mem_dout[15:0]}};
            end
            default: begin
                sel_next  = 4'b1111;
                dout_next = mem_dout;
            end
        endcase
    end

    always_comb begin
        rd_byte = wb_din[8*rd_lane +: 8];
        rd_half = rd_lane[1] ? wb_din[31:16] : wb_din[15:0];
        case (rd_type)
            2'b00:   rd_data = {{24{rd_ext & rd_byte[7]}}, rd_byte};
            2'b01:   rd_data = {{16{rd_ext & rd_half[15]}}, rd_half};
            default: rd_data = wb_din;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            wb_cyc  <= 1'b0;
            wb_stb  <= 1'b0;
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_sel  <= '0;
            wb_dout <= '0;
            mem_din <= '0;
            bus_err <= 1'b0;
            to_cnt  <= '0;
            rd_type <= '0;
            rd_lane <= '0;
            rd_ext  <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req && !mem_unalign) begin
                        wb_cyc  <= 1'b1;
                        wb_stb  <= 1'b1;
                        wb_we   <= mem_wen;
                        wb_addr <= mem_addr[31:2];
                        wb_sel  <= sel_next;
                        wb_dout <= dout_next;
                        rd_type <= mem_type;
                        rd_lane <= mem_addr[1:0];
                        rd_ext  <= mem_ext;
                        to_cnt  <= '0;
                        state   <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (wb_ack) begin
                        wb_cyc <= 1'b0;
                        wb_stb <= 1'b0;
                        if (!wb_we) begin
                            mem_din <= rd_data;
                        end
                        state <= S_DONE;
                    end else if (to_hit) begin
                        wb_cyc  <= 1'b0;
                        wb_stb  <= 1'b0;
                        mem_din <= '0;
                        bus_err <= 1'b1;
                        state   <= S_DONE;
                    end else if (TO_EN) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // The core still presents the same request while locked;
                    // returning to IDLE now would issue it a second time.
                    if (!dc_lock) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed plan cases plus randomized
// accesses against a word/lane arithmetic reference model.
module tb_dmem_responder;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        mem_ren;
    logic        mem_wen;
    logic [1:0]  mem_type;
    logic        mem_ext;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        mem_unalign;
    logic        dc_lock;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [29:0] wb_addr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dout;
    logic [31:0] wb_din;
    logic        wb_ack;
    logic        bus_err;

    int          tests_run;
    int          tests_failed;
    logic [31:0] exp_din;

    dmem_responder #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_type   (mem_type),
        .mem_ext    (mem_ext),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .mem_din    (mem_din),
        .mem_stall  (mem_stall),
        .mem_unalign(mem_unalign),
        .dc_lock    (dc_lock),
        .wb_cyc     (wb_cyc),
        .wb_stb     (wb_stb),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_sel     (wb_sel),
        .wb_dout    (wb_dout),
        .wb_din     (wb_din),
        .wb_ack     (wb_ack),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete access; the bench acts as a slave with `waits` wait states.
    task automatic run_access(input string nm, input logic wr, input logic rd_too,
                              input logic [1:0] typ, input logic ext,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int waits,
                              input int lock_cyc);
        logic [31:0] e_dout;
        logic [31:0] e_rd;
        logic [31:0] sh;
        logic [3:0]  e_sel;
        int          lane;
        int          n_stall;
        int          n_stb;
        int          e_stall;
        int          e_stb;
        logic        done;
        logic        timeout;
        lane    = int'(addr[1:0]);
        sh      = rdata >> (8 * lane);
        timeout = (waits >= TO);
        case (typ)
            2'b00: begin
                e_sel  = 4'b0001 << lane;
                e_dout = {24'd0, wdata[7:0]} * 32'h0101_0101;
                e_rd   = {24'd0, sh[7:0]};
                if (ext && sh[7]) e_rd = e_rd | 32'hFFFF_FF00;
            end
            2'b01: begin
                e_sel  = 4'b0011 << (lane & 2);
                e_dout = {16'd0, wdata[15:0]} * 32'h0001_0001;
                e_rd   = {16'd0, sh[15:0]};
                if (ext && sh[15]) e_rd = e_rd | 32'hFFFF_0000;
            end
            default: begin
                e_sel  = 4'b1111;
                e_dout = wdata;
                e_rd   = rdata;
            end
        endcase
        e_stall = timeout ? TO + 1 : waits + 2;
        e_stb   = timeout ? TO : waits + 1;
        n_stall = 0;
        n_stb   = 0;
        done    = 1'b0;
        @(negedge clk);
        mem_ren  = !wr | rd_too;
        mem_wen  = wr;
        mem_type = typ;
        mem_ext  = ext;
        mem_addr = addr;
        mem_dout = wdata;
        dc_lock  = 1'b0;
        wb_ack   = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (!mem_stall) begin
                done = 1'b1;
            end else begin
                n_stall++;
                if (wb_stb) begin
                    n_stb++;
                    if (n_stb == 1) begin
                        tests_run++;
                        if (wb_cyc !== 1'b1 || wb_we !== wr || wb_addr !== addr[31:2] ||
                            wb_sel !== e_sel || (wr && wb_dout !== e_dout)) begin
                            tests_failed++;
                            $display("FAIL %s bus: cyc=%b we=%b addr=%h sel=%b dout=%h, want cyc=1 we=%b addr=%h sel=%b dout=%h",
                                     nm, wb_cyc, wb_we, wb_addr, wb_sel, wb_dout,
                                     wr, addr[31:2], e_sel, e_dout);
                        end
                    end
                    wb_ack = (n_stb > waits);
                    wb_din = wb_ack ? rdata : $urandom;
                end
                @(negedge clk);
            end
        end
        wb_ack = 1'b0;
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL %s budget: stall still high after 40 cycles", nm);
        end
        if (timeout) exp_din = 32'd0;
        else if (!wr) exp_din = e_rd;
        tests_run++;
        if (n_stall != e_stall || n_stb != e_stb) begin
            tests_failed++;
            $display("FAIL %s timing: stall_cycles=%0d stb_cycles=%0d, want %0d %0d",
                     nm, n_stall, n_stb, e_stall, e_stb);
        end
        tests_run++;
        if (mem_din !== exp_din || bus_err !== timeout || wb_cyc !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s result: din=%h bus_err=%b cyc=%b, want din=%h bus_err=%b cyc=0",
                     nm, mem_din, bus_err, wb_cyc, exp_din, timeout);
        end
        for (int i = 0; i < lock_cyc; i++) begin
            dc_lock = 1'b1;
            @(negedge clk);
            #1;
            tests_run++;
            if (wb_stb !== 1'b0 || mem_stall !== 1'b0 || bus_err !== 1'b0 || mem_din !== exp_din) begin
                tests_failed++;
                $display("FAIL %s lock%0d: stb=%b stall=%b bus_err=%b din=%h, want 0 0 0 %h",
                         nm, i, wb_stb, mem_stall, bus_err, mem_din, exp_din);
            end
        end
        mem_ren = 1'b0;
        mem_wen = 1'b0;
        dc_lock = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_we !== 1'b0 || wb_addr !== 30'd0 ||
            wb_sel !== 4'd0 || wb_dout !== 32'd0 || mem_din !== 32'd0 ||
            bus_err !== 1'b0 || mem_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: cyc=%b stb=%b we=%b addr=%h sel=%b dout=%h din=%h err=%b stall=%b, want all 0",
                     wb_cyc, wb_stb, wb_we, wb_addr, wb_sel, wb_dout, mem_din, bus_err, mem_stall);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_din = 32'd0;
    endtask

    task automatic test_directed();
        run_access("word_rd", 1'b0, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h89AB_CDEF, 0, 0);
        run_access("byte_sx", 1'b0, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h8012_3456, 0, 1);
        run_access("byte_zx", 1'b0, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h8012_3456, 1, 0);
        run_access("half_wr_lock", 1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0000_BEEF, 32'h0, 0, 5);
        run_access("both_is_wr", 1'b1, 1'b1, 2'b10, 1'b0, 32'h300, 32'h1234_5678, 32'hFFFF_FFFF, 2, 0);
    endtask

    task automatic test_unaligned();
        logic [1:0]  typs  [4] = '{2'b11, 2'b01, 2'b10, 2'b01};
        logic [31:0] addrs [4] = '{32'h101, 32'h101, 32'h102, 32'h203};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_ren  = 1'b1;
            mem_type = typs[k];
            mem_addr = addrs[k];
            for (int c = 0; c < 3; c++) begin
                #1;
                tests_run++;
                if (mem_unalign !== 1'b1 || mem_stall !== 1'b0 || wb_cyc !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL unalign%0d c%0d: unalign=%b stall=%b cyc=%b, want 1 0 0",
                             k, c, mem_unalign, mem_stall, wb_cyc);
                end
                @(negedge clk);
            end
            mem_ren = 1'b0;
        end
    endtask

    task automatic test_timeout();
        run_access("timeout_rd", 1'b0, 1'b0, 2'b11, 1'b0, 32'h400, 32'h0, 32'hDEAD_BEEF, 100, 2);
        run_access("after_to", 1'b0, 1'b0, 2'b01, 1'b1, 32'h402, 32'h0, 32'h9876_0000, 0, 0);
    endtask

    task automatic test_reset_in_bus();
        @(negedge clk);
        mem_ren  = 1'b1;
        mem_type = 2'b11;
        mem_addr = 32'h500;
        wb_ack   = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || mem_din !== 32'd0) begin
            tests_failed++;
            $display("FAIL rst_in_bus: cyc=%b stb=%b din=%h, want 0 0 0", wb_cyc, wb_stb, mem_din);
        end
        mem_ren = 1'b0;
        exp_din = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        run_access("post_rst", 1'b0, 1'b0, 2'b11, 1'b0, 32'h504, 32'h0, 32'h0BAD_F00D, 0, 0);
    endtask

    task automatic test_random();
        logic [1:0]  typ;
        logic [1:0]  lane;
        logic [31:0] addr;
        for (int n = 0; n < 40; n++) begin
            typ  = 2'($urandom_range(0, 3));
            lane = 2'($urandom_range(0, 3));
            if (typ == 2'b01) lane = lane & 2'b10;
            if (typ[1]) lane = 2'b00;
            addr = {$urandom, lane} ;
            addr[1:0] = lane;
            run_access("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), typ,
                       1'($urandom_range(0, 1)), addr, $urandom, $urandom,
                       $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_din      = 32'd0;
        rst          = 1'b1;
        mem_ren      = 1'b0;
        mem_wen      = 1'b0;
        mem_type     = 2'b00;
        mem_ext      = 1'b0;
        mem_addr     = 32'd0;
        mem_dout     = 32'd0;
        dc_lock      = 1'b0;
        wb_din       = 32'd0;
        wb_ack       = 1'b0;
        test_reset();
        test_directed();
        test_unaligned();
        test_timeout();
        test_reset_in_bus();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
